// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Copies one SPR_W x SPR_H sprite from a synchronous sprite ROM into the
//   FB_W x FB_H RGBA4441 framebuffer at (x_pos, y_pos). Transparent pixels
//   (A = bit 0 = 0) and pixels falling outside the framebuffer are skipped.
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, x_pos, y_pos: blit request and sprite top-left corner
//   busy, done         : blit in progress / one-cycle completion pulse
//   src_addr, src_data : sprite ROM address (registered) and data (1-cycle latency)
//   fb_we, fb_addr,
//   fb_data, fb_ready  : framebuffer write port, accepted when fb_we & fb_ready
module sprite_blitter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int FB_ADDR_W  = 15,
  parameter int SPR_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            x_pos,
  input  logic [6:0]            y_pos,
  output logic                  busy,
  output logic                  done,
  output logic [SPR_ADDR_W-1:0] src_addr,
  input  logic [12:0]           src_data,
  output logic                  fb_we,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [12:0]           fb_data,
  input  logic                  fb_ready
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE} state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  state_t                state_q;
  logic [7:0]            x0_q;
  logic [6:0]            y0_q;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [SPR_ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [FB_ADDR_W-1:0]  fb_addr_q, pix_addr;
  logic [12:0]           fb_data_q;
  logic                  fb_we_q, busy_q, done_q;

  logic [8:0] fx;
  logic [7:0] fy;
  logic       skip, last_col, last_pix, adv;

  always_comb begin
    // Positions are widened before adding so a sprite hanging off the
    // right/bottom edge is clipped instead of wrapping to column/row 0.
    fx       = {1'b0, x0_q} + 9'(col_q);
    fy       = {1'b0, y0_q} + 8'(row_q);
    skip     = ~src_data[0] | (int'(fx) >= FB_W) | (int'(fy) >= FB_H);
    pix_addr = FB_ADDR_W'(int'(fy) * FB_W + int'(fx));

    last_col = (int'(col_q) == SPR_W - 1);
    last_pix = last_col && (int'(row_q) == SPR_H - 1);
    col_d    = last_col ? '0 : col_q + 1'b1;
    row_d    = last_col ? row_q + 1'b1 : row_q;
    src_addr_d = SPR_ADDR_W'(int'(row_d) * SPR_W + int'(col_d));

    // A pixel is finished when it is skipped in CAPTURE or accepted in WRITE.
    adv = ((state_q == S_CAPTURE) && skip) || ((state_q == S_WRITE) && fb_ready);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      src_addr_q <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      fb_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x0_q       <= x_pos;
            y0_q       <= y_pos;
            col_q      <= '0;
            row_q      <= '0;
            src_addr_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_READ;
          end
        end
        S_READ: state_q <= S_CAPTURE;
        S_CAPTURE: begin
          if (!skip) begin
            fb_addr_q <= pix_addr;
            fb_data_q <= src_data;
            fb_we_q   <= 1'b1;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (fb_ready) fb_we_q <= 1'b0;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (adv) begin
        col_q <= col_d;
        row_q <= row_d;
        if (last_pix) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end else begin
          src_addr_q <= src_addr_d;
          state_q    <= S_READ;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign src_addr = src_addr_q;
  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  x_pos = '0;
  logic [6:0]  y_pos = '0;
  logic        busy, done, fb_we;
  logic [7:0]  src_addr;
  logic [12:0] src_data = '0;
  logic [14:0] fb_addr;
  logic [12:0] fb_data;
  logic        fb_ready = 1'b1;

  always #5 clk = ~clk;

  sprite_blitter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_pos(x_pos), .y_pos(y_pos),
    .busy(busy), .done(done), .src_addr(src_addr), .src_data(src_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready)
  );

  // Synchronous sprite ROM
  logic [12:0] rom [256];
  always @(posedge clk) src_data <= rom[src_addr];

  typedef struct { int a; int d; } wr_t;
  wr_t exp_q[$];

  int errors = 0, checks = 0;
  int nw, ns, stalls, cyc, done_cyc, wr_count, first_run, run;
  int first_addr, last_addr, max_addr, prev_addr, prev_data;
  bit active = 0, prev_stall = 0;
  int rdy_mode = 0, stall_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: the list of writes a blit must produce, in raster order.
  function automatic void build_expected(input int x, input int y);
    exp_q.delete();
    nw = 0;
    ns = 0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int idx;
        idx = r * 16 + c;
        if (rom[idx][0] && (x + c < 160) && (y + r < 120)) begin
          exp_q.push_back('{(y + r) * 160 + x + c, int'(rom[idx])});
          nw++;
        end else begin
          ns++;
        end
      end
    end
  endfunction

  // Compare process: every cycle of a blit, and idle behaviour outside one.
  always @(negedge clk) begin
    if (rst_n && active) begin
      cyc++;
      if (done) begin
        chk("done_cycle", cyc, 1 + 3 * nw + 2 * ns + stalls);
        chk("busy_at_done", busy, 0);
        chk("we_at_done", fb_we, 0);
        chk("writes_missing", exp_q.size(), 0);
        done_cyc = cyc;
        active = 0;
      end else begin
        chk("busy", busy, 1);
        if (fb_we) begin
          run++;
          if (prev_stall) begin
            chk("hold_addr", fb_addr, prev_addr);
            chk("hold_data", fb_data, prev_data);
          end
          if (fb_ready) begin
            if (exp_q.size() == 0) begin
              chk("write_count", wr_count + 1, nw);
            end else begin
              wr_t e;
              e = exp_q.pop_front();
              chk("wr_addr", fb_addr, e.a);
              chk("wr_data", fb_data, e.d);
            end
            if (wr_count == 0) begin
              first_run  = run;
              first_addr = fb_addr;
            end
            last_addr = fb_addr;
            if (fb_addr > max_addr) max_addr = fb_addr;
            wr_count++;
            run = 0;
            prev_stall = 0;
          end else begin
            stalls++;
            prev_stall = 1;
            prev_addr = fb_addr;
            prev_data = fb_data;
          end
        end else begin
          if (prev_stall) chk("hold_we", fb_we, 1);
          prev_stall = 0;
          run = 0;
        end
      end
    end else if (rst_n) begin
      chk("idle_we", fb_we, 0);
      chk("idle_busy", busy, 0);
    end
  end

  // fb_ready driver: 0 = always ready, 1 = random, 2 = stall first write, 3 = never ready
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: fb_ready = 1'b1;
      1: fb_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (fb_we && stall_left > 0) begin
          fb_ready = 1'b0;
          stall_left--;
        end else begin
          fb_ready = 1'b1;
        end
      end
      default: fb_ready = 1'b0;
    endcase
  end

  task automatic begin_blit(input int x, input int y);
    build_expected(x, y);
    stalls = 0; wr_count = 0; first_run = 0; run = 0; prev_stall = 0;
    first_addr = -1; last_addr = -1; max_addr = 0; done_cyc = -1;
    x_pos = 8'(x);
    y_pos = 7'(y);
    start = 1'b1;
    @(posedge clk);
    cyc = 0;
    active = 1;
    #1;
    start = 1'b0;
  endtask

  // Runs one blit; with poke set, issues ignored starts at cycle 100 and in DONE.
  task automatic run_blit(input int x, input int y, input bit poke);
    int  k;
    bit  got;
    begin_blit(x, y);
    k = 1;
    got = 0;
    while (!got && k < 6000) begin
      start = 1'b0;
      if (poke && k == 100) begin
        x_pos = 8'd40;
        y_pos = 7'd40;
        start = 1'b1;
      end
      if (done) begin
        if (poke) start = 1'b1;
        got = 1;
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    if (!got) begin
      chk("blit_timeout", done, 1);
      active = 0;
    end
  endtask

  task automatic rom_opaque();
    for (int n = 0; n < 256; n++) rom[n] = {8'(n), 4'h5, 1'b1};
  endtask

  initial begin
    rom_opaque();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_src_addr", src_addr, 0);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Full opaque blit
    run_blit(0, 0, 0);
    chk("opaque_done", done_cyc, 769);
    chk("opaque_writes", wr_count, 256);
    chk("opaque_last", last_addr, 15 * 160 + 15);
    chk("opaque_run", first_run, 1);

    // Transparent even columns
    for (int n = 0; n < 256; n++) rom[n] = {8'(n), 4'h5, n[0]};
    run_blit(0, 0, 0);
    chk("transp_done", done_cyc, 641);
    chk("transp_writes", wr_count, 128);
    chk("transp_first", first_addr, 1);

    // Clipping at the bottom-right corner
    rom_opaque();
    run_blit(150, 110, 0);
    chk("clip_done", done_cyc, 613);
    chk("clip_writes", wr_count, 100);
    chk("clip_first", first_addr, 17750);
    chk("clip_last", last_addr, 19199);
    chk("clip_in_range", max_addr < 19200, 1);

    // Backpressure on the first write
    stall_left = 5;
    rdy_mode = 2;
    run_blit(0, 0, 0);
    chk("bp_done", done_cyc, 774);
    chk("bp_hold_cycles", first_run, 6);
    chk("bp_writes", wr_count, 256);
    rdy_mode = 0;

    // Starts while busy and in DONE are ignored; next IDLE start is taken
    run_blit(0, 0, 1);
    chk("poke_done", done_cyc, 769);
    chk("poke_writes", wr_count, 256);
    run_blit(5, 3, 0);
    chk("after_poke_writes", wr_count, 256);

    // Entirely off-screen: every pixel skipped
    run_blit(255, 127, 0);
    chk("offscreen_done", done_cyc, 513);
    chk("offscreen_writes", wr_count, 0);

    // Randomized sprites, positions and backpressure
    rdy_mode = 1;
    for (int t = 0; t < 8; t++) begin
      for (int n = 0; n < 256; n++) rom[n] = {12'($urandom), ($urandom_range(0, 3) != 0)};
      run_blit($urandom_range(0, 255), $urandom_range(0, 127), 0);
      chk("rand_writes", wr_count, nw);
    end

    // Reset while stalled in WRITE
    rom_opaque();
    rdy_mode = 3;
    begin_blit(0, 0);
    for (int i = 0; i < 20 && !fb_we; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_write", fb_we, 1);
    @(posedge clk);
    #3;
    active = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_we", fb_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    #30 rst_n = 1'b1;
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    run_blit(0, 0, 0);
    chk("postrst_done", done_cyc, 769);
    chk("postrst_writes", wr_count, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
